decode_queue: RTL and testbench
===============================

# decode_queue

Parameterised instruction-decode stage with a DEPTH-entry in-order queue between fetch and execute. Replaces a single enable-gated decode register with a valid/ready handshake, back-pressure, flush and occupancy reporting. Each accepted instruction word is stored with its PC pair and `distinct` tag. The head entry is presented with all MIPS-style fields split out and the immediate pre-extended. Control decode (opcode/funct to control signals) is done downstream from the `opcode`/`funct` outputs.

## Interface
- INST_MEM_WIDTH, 2, width of `pc`/`pc1` and their outputs
- DEPTH, 2, queue entries; power of two, ≥2

- CLK  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all queued entries (branch/jump redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept; `count < DEPTH`
- inst  in  32  instruction word
- pc  in  INST_MEM_WIDTH  instruction address
- pc1  in  INST_MEM_WIDTH  sequential next address
- distinct  in  1  side tag carried with the entry
- out_valid  out  1  head entry present
- out_ready  in  1  execute consumes head
- opcode  out  6  head `inst[31:26]`
- rs, rt, rd, sa  out  5 each  head `inst[25:21]`, `[20:16]`, `[15:11]`, `[10:6]`
- funct  out  6  head `inst[5:0]`
- immediate  out  16  head `inst[15:0]`
- imm_sext  out  32  `immediate` sign-extended
- imm_zext  out  32  `immediate` zero-extended
- inst_index  out  26  head `inst[25:0]`
- is_nop  out  1  head word == 32'h0000_0000
- pc_out, pc1_out  out  INST_MEM_WIDTH  head `pc`, `pc1`
- distinct_out  out  1  head `distinct`
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH entries of {inst, pc, pc1, distinct}. The write pointer `wp` and read pointer `rp` are each $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push = `in_valid & in_ready`: writes the entry at `wp`, then `wp+1`.
- Pop = `out_valid & out_ready`: advances `rp` by 1.
- `count` next value = count + push − pop. Push and pop in the same cycle leave `count` unchanged.
- `in_ready` is a function of registered `count` only. It has no combinational path from `out_ready`.
  - Full (`count == DEPTH`): `in_ready` = 0, even if a pop happens that cycle.
- `out_valid` = (`count != 0`).
- Empty queue (`count == 0`): all field outputs, `pc_out`, `pc1_out`, `distinct_out` and `is_nop` are forced to 0. They are never stale.
- Field outputs are a combinational split of the head entry, taken from the stored word at `rp`.
- `imm_sext` = {16{imm[15]}, imm}. `imm_zext` = {16'h0, imm}.
- `flush`: next cycle `wp` = `rp` = `count` = 0. Any push or pop in the flush cycle is discarded; flush wins over both.
- `reset`: same as flush, and additionally clears all storage to 0.
- Ordering: strictly FIFO. There is no bypass; an instruction is never visible in the cycle it is accepted.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `count` = 0. All field, pc and tag outputs are 0; `imm_sext` = `imm_zext` = 0; `is_nop` = 0.
- Latency: push at edge N, so `out_valid` = 1 and the fields are valid after edge N. Minimum one cycle from input to output.
- Throughput: one instruction per cycle sustained when `out_ready` is held at 1 and 1 ≤ `count` < DEPTH.
- Back-pressure:
  - With `out_ready` = 0, the head outputs hold stable.
  - DEPTH consecutive pushes set `in_ready` = 0 after the DEPTH-th edge.
  - `in_ready` returns to 1 the cycle after the first pop.
- Wrap-around: after `wp` or `rp` reaches DEPTH−1, the next increment goes to 0. Order is preserved across the wrap.
- Reset or flush asserted mid-stream: effective at the next edge. `out_valid` = 0 after that edge, regardless of `in_valid`/`out_ready` in the same cycle.

## Test plan
- Reset then idle: after reset, `in_ready` = 1, `out_valid` = 0, `count` = 0, all fields 0. Push 32'h2108_FFFF (pc = 1, pc1 = 2, distinct = 1). Next cycle: `opcode` = 6'h08, `rs` = 8, `rt` = 8, `immediate` = 16'hFFFF, `imm_sext` = 32'hFFFF_FFFF, `imm_zext` = 32'h0000_FFFF, `pc_out` = 1, `pc1_out` = 2, `distinct_out` = 1.
- Fill/drain with DEPTH = 4 and `out_ready` = 0: push words A, B, C, D. After the 4th edge, `in_ready` = 0 and `count` = 4; a 5th word E offered stays unaccepted. Raise `out_ready`: outputs are A, B, C, D in order, then `out_valid` = 0.
- Streaming: `in_valid` = `out_ready` = 1 for 20 cycles with incrementing words. `count` stays 1 and each word appears exactly one cycle after acceptance. This exercises pointer wrap 5 times.
- Simultaneous push and pop at `count` = 1: `count` stays 1 and the new head is the pushed word.
- Flush while `count` = 3, with `in_valid` = 1 and `out_ready` = 1 in the same cycle: next cycle `count` = 0, `out_valid` = 0, `in_ready` = 1, and the offered word is not stored. A subsequent push appears alone.
- `is_nop`: pushing 32'h0 gives `is_nop` = 1 with `out_valid` = 1. Pushing 32'h0000_0020 gives `is_nop` = 0 and `funct` = 6'h20.

Source files
------------

// File: rtl/decode_queue.sv
// Instruction-decode stage: DEPTH-entry in-order queue between fetch and execute.
// The head entry is split into MIPS-style fields, with the immediate pre-extended.
module decode_queue #(
    parameter int INST_MEM_WIDTH = 2,
    parameter int DEPTH          = 2
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   inst,
    input  logic [INST_MEM_WIDTH-1:0]     pc,
    input  logic [INST_MEM_WIDTH-1:0]     pc1,
    input  logic                          distinct,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [5:0]                    opcode,
    output logic [4:0]                    rs,
    output logic [4:0]                    rt,
    output logic [4:0]                    rd,
    output logic [4:0]                    sa,
    output logic [5:0]                    funct,
    output logic [15:0]                   immediate,
    output logic [31:0]                   imm_sext,
    output logic [31:0]                   imm_zext,
    output logic [25:0]                   inst_index,
    output logic                          is_nop,
    output logic [INST_MEM_WIDTH-1:0]     pc_out,
    output logic [INST_MEM_WIDTH-1:0]     pc1_out,
    output logic                          distinct_out,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]               inst_mem     [DEPTH];
    logic [INST_MEM_WIDTH-1:0] pc_mem       [DEPTH];
    logic [INST_MEM_WIDTH-1:0] pc1_mem      [DEPTH];
    logic                      distinct_mem [DEPTH];

    logic [PW-1:0] wp_reg, rp_reg;
    logic [CW-1:0] count_reg;
    logic          push, pop;

    // in_ready depends on registered occupancy only, so a full queue stays closed
    // even during a pop and there is no path from out_ready.
    assign in_ready  = (count_reg != CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_reg;

    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            wp_reg    <= '0;
            rp_reg    <= '0;
            count_reg <= '0;
        end else begin
            if (push)
                wp_reg <= wp_reg + PW'(1);
            if (pop)
                rp_reg <= rp_reg + PW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (reset) begin
                    inst_mem[gi]     <= '0;
                    pc_mem[gi]       <= '0;
                    pc1_mem[gi]      <= '0;
                    distinct_mem[gi] <= 1'b0;
                end else if (push && !flush && wp_reg == PW'(gi)) begin
                    inst_mem[gi]     <= inst;
                    pc_mem[gi]       <= pc;
                    pc1_mem[gi]      <= pc1;
                    distinct_mem[gi] <= distinct;
                end
            end
        end
    endgenerate

    // An empty queue presents all-zero fields so downstream never sees stale data.
    logic [31:0] head_word;
    assign head_word = out_valid ? inst_mem[rp_reg] : 32'h0;

    assign opcode       = head_word[31:26];
    assign rs           = head_word[25:21];
    assign rt           = head_word[20:16];
    assign rd           = head_word[15:11];
    assign sa           = head_word[10:6];
    assign funct        = head_word[5:0];
    assign immediate    = head_word[15:0];
    assign imm_sext     = {{16{head_word[15]}}, head_word[15:0]};
    assign imm_zext     = {16'h0, head_word[15:0]};
    assign inst_index   = head_word[25:0];
    assign is_nop       = out_valid && (head_word == 32'h0);
    assign pc_out       = out_valid ? pc_mem[rp_reg] : '0;
    assign pc1_out      = out_valid ? pc1_mem[rp_reg] : '0;
    assign distinct_out = out_valid ? distinct_mem[rp_reg] : 1'b0;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed test-plan sequences plus randomized traffic,
// all compared every cycle against a queue-based reference model.
module tb_decode_queue;

    localparam int IW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          CLK = 1'b0;
    logic          reset = 1'b0, flush = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0, distinct = 1'b0;
    logic [31:0]   inst = '0;
    logic [IW-1:0] pc = '0, pc1 = '0;
    logic          in_ready, out_valid, is_nop, distinct_out;
    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd, sa;
    logic [15:0]   immediate;
    logic [31:0]   imm_sext, imm_zext;
    logic [25:0]   inst_index;
    logic [IW-1:0] pc_out, pc1_out;
    logic [CW-1:0] count;

    decode_queue #(.INST_MEM_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .pc1(pc1), .distinct(distinct),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .funct(funct),
        .immediate(immediate), .imm_sext(imm_sext), .imm_zext(imm_zext),
        .inst_index(inst_index), .is_nop(is_nop),
        .pc_out(pc_out), .pc1_out(pc1_out), .distinct_out(distinct_out),
        .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0]   w;
        logic [IW-1:0] p;
        logic [IW-1:0] p1;
        logic          d;
    } entry_t;

    entry_t q[$];
    bit     started = 0;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of entries, updated with the inputs seen at each edge.
    always @(posedge CLK) begin
        if (reset || flush) begin
            q.delete();
        end else begin
            bit do_pop, do_push;
            do_pop  = out_ready && (q.size() > 0);
            do_push = in_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{w: inst, p: pc, p1: pc1, d: distinct});
        end
        if (reset) started = 1;
    end

    always @(negedge CLK) begin
        if (started) begin
            entry_t h;
            h = (q.size() > 0) ? q[0] : '0;
            chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("count", 64'(count), 64'(q.size()));
            chk("opcode", 64'(opcode), 64'(h.w[31:26]));
            chk("rs", 64'(rs), 64'(h.w[25:21]));
            chk("rt", 64'(rt), 64'(h.w[20:16]));
            chk("rd", 64'(rd), 64'(h.w[15:11]));
            chk("sa", 64'(sa), 64'(h.w[10:6]));
            chk("funct", 64'(funct), 64'(h.w[5:0]));
            chk("immediate", 64'(immediate), 64'(h.w[15:0]));
            chk("imm_sext", 64'(imm_sext), 64'({{16{h.w[15]}}, h.w[15:0]}));
            chk("imm_zext", 64'(imm_zext), 64'({16'h0, h.w[15:0]}));
            chk("inst_index", 64'(inst_index), 64'(h.w[25:0]));
            chk("is_nop", 64'(is_nop), 64'((q.size() > 0) && (h.w == 32'h0)));
            chk("pc_out", 64'(pc_out), 64'(h.p));
            chk("pc1_out", 64'(pc1_out), 64'(h.p1));
            chk("distinct_out", 64'(distinct_out), 64'(h.d));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] head_word();
        return {opcode, inst_index};
    endfunction

    initial begin
        // Reset then idle
        reset = 1; step(); step(); reset = 0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_imm_sext", 64'(imm_sext), 64'd0);
        chk("rst_is_nop", 64'(is_nop), 64'd0);

        in_valid = 1; inst = 32'h2108_FFFF; pc = 1; pc1 = 2; distinct = 1;
        step(); in_valid = 0;
        chk("lit_opcode", 64'(opcode), 64'h08);
        chk("lit_rs", 64'(rs), 64'd8);
        chk("lit_rt", 64'(rt), 64'd8);
        chk("lit_immediate", 64'(immediate), 64'hFFFF);
        chk("lit_imm_sext", 64'(imm_sext), 64'hFFFF_FFFF);
        chk("lit_imm_zext", 64'(imm_zext), 64'h0000_FFFF);
        chk("lit_pc_out", 64'(pc_out), 64'd1);
        chk("lit_pc1_out", 64'(pc1_out), 64'd2);
        chk("lit_distinct", 64'(distinct_out), 64'd1);
        out_ready = 1; step(); out_ready = 0;
        $display("reset/first push done: count=%0d", count);

        // Fill/drain with back-pressure
        distinct = 0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; inst = 32'hA000_0000 + 32'(i); pc = IW'(i); pc1 = IW'(i + 1);
            step();
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        inst = 32'hEEEE_EEEE; step(); in_valid = 0;
        chk("full_hold_count", 64'(count), 64'd4);
        chk("full_hold_head", 64'(head_word()), 64'hA000_0000);
        out_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 64'(head_word()), 64'(32'hA000_0000 + 32'(i)));
            step();
            if (i == 0) chk("ready_after_pop", 64'(in_ready), 64'd1);
        end
        chk("drain_empty", 64'(out_valid), 64'd0);
        out_ready = 0;
        $display("fill/drain done: count=%0d", count);

        // Streaming: one word per cycle, count stays at 1
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            inst = 32'h1000_0000 + 32'(i); pc = IW'(i);
            step();
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_head", 64'(head_word()), 64'(32'h1000_0000 + 32'(i)));
        end
        in_valid = 0; step(); out_ready = 0;
        $display("streaming done: count=%0d", count);

        // Flush at count 3 with a push and pop offered in the same cycle
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; inst = 32'hB000_0000 + 32'(i); step();
        end
        chk("pre_flush_count", 64'(count), 64'd3);
        flush = 1; in_valid = 1; out_ready = 1; inst = 32'hBAD0_BAD0; step();
        flush = 0; in_valid = 0; out_ready = 0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1; inst = 32'hC0DE_0001; step(); in_valid = 0;
        chk("post_flush_count", 64'(count), 64'd1);
        chk("post_flush_head", 64'(head_word()), 64'hC0DE_0001);
        out_ready = 1; step(); out_ready = 0;
        $display("flush done: count=%0d", count);

        // is_nop
        in_valid = 1; inst = 32'h0; step();
        chk("nop_is_nop", 64'(is_nop), 64'd1);
        chk("nop_out_valid", 64'(out_valid), 64'd1);
        inst = 32'h0000_0020; out_ready = 1; step(); in_valid = 0; out_ready = 0;
        chk("add_is_nop", 64'(is_nop), 64'd0);
        chk("add_funct", 64'(funct), 64'h20);
        out_ready = 1; step(); out_ready = 0;
        $display("is_nop done: count=%0d", count);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            inst      = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            pc        = IW'($urandom);
            pc1       = IW'($urandom);
            distinct  = 1'($urandom);
            flush     = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 0; flush = 0; in_valid = 0; out_ready = 0;
        step();
        $display("random phase done: count=%0d", count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
